tick_core: RTL and testbench

- Parametrised successor to the single-tick 16-bit core: multi-cycle fetch/execute/writeback processor with an internal regfile and ALU.
- Drives an instruction ROM via `address` and executes one instruction per tick; the tick comes from an internal divider, so execution can be slowed for board-level debug.
- Adds SUB/logic ops, branches, HALT and a qualified output strobe.
- Sits between the instruction ROM and the display/LED output logic.

---
 rtl/tick_core.sv | 145 ++++++++++++++
 tb/tb_tick_core.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tick_core.sv
// Multi-cycle 16-bit-instruction core: WAIT/FETCH/EXEC/WB sequencing paced by an
// internal tick divider, with an 8-entry register file, ALU, branches, HALT and OUT strobe.
module tick_core #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instruction,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              halted
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {S_WAIT, S_FETCH, S_EXEC, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB  = 4'h3,
    OP_AND  = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_BEQZ = 4'h7,
    OP_JMP  = 4'h8, OP_HALT = 4'hE, OP_OUT = 4'hF
  } op_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic [15:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic                take_q, take_d;
  logic [DATA_W-1:0]   regs_q [8];
  logic                we;

  op_t               op;
  logic [2:0]        ra, rb;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] opa, opb;

  assign op   = op_t'(ir_q[15:12]);
  assign ra   = ir_q[11:9];
  assign rb   = ir_q[8:6];
  assign imm8 = ir_q[7:0];
  assign opa  = regs_q[ra];
  assign opb  = regs_q[rb];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    result_d = result_q;
    valid_d  = 1'b0;
    halted_d = halted_q;
    ir_d     = ir_q;
    alu_d    = alu_q;
    take_d   = take_q;
    we       = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_LDI:  alu_d = DATA_W'(imm8);
          OP_ADD:  alu_d = opa + opb;
          OP_SUB:  alu_d = opa - opb;
          OP_AND:  alu_d = opa & opb;
          OP_OR:   alu_d = opa | opb;
          OP_XOR:  alu_d = opa ^ opb;
          default: alu_d = opa;
        endcase
        take_d = (op == OP_JMP) || ((op == OP_BEQZ) && (opa == '0));
        // OUT is registered on entry to WB so result and strobe line up in the WB cycle
        if (op == OP_OUT) begin
          result_d = opa;
          valid_d  = 1'b1;
        end
        state_d = S_WB;
      end
      S_WB: begin
        we = (op == OP_LDI) || (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
        if (op == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          addr_d  = take_q ? ADDR_W'(imm8) : addr_q + ADDR_W'(1);
          state_d = S_WAIT;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_WAIT;
      cnt_q    <= '0;
      addr_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      ir_q     <= '0;
      alu_q    <= '0;
      take_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      ir_q     <= ir_d;
      alu_q    <= alu_d;
      take_q   <= take_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[ra] <= alu_q;
    end
  end

  assign address      = addr_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_tick_core.sv
// Scoreboard bench for tick_core with TICK_DIV=2 (5-cycle instruction period).
module tb_tick_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instruction;
  logic [2:0]  address;
  logic [15:0] result;
  logic        result_valid;
  logic        halted;

  logic [15:0] rom [8];
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_v = 1'b0;

  assign instruction = rom[address];

  tick_core #(.DATA_W(16), .ADDR_W(3), .TICK_DIV(2)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .address(address),
    .result(result), .result_valid(result_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: every OUT strobe pops one expected result
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_v && result_valid) chk("vpulse", 32'(result_valid), 32'd0);
      if (result_valid) begin
        if (exp_q.size() == 0) chk("unexp_valid", 32'd1, 32'd0);
        else chk("result", 32'(result), 32'(exp_q.pop_front()));
      end
    end
    prev_v = result_valid;
  end

  task automatic clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step_addr(input logic [2:0] exp);
    int n = 0;
    logic [2:0] prev = address;
    do begin
      @(negedge clk);
      n++;
    end while (address == prev && n < 20);
    chk("addr", 32'(address), 32'(exp));
    chk("period", 32'(n), 32'd5);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_wait", 32'(halted), 32'd1);
  endtask

  task automatic wait_addr(input logic [2:0] a, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (address != a && n < budget);
    chk("addr_wait", 32'(address), 32'(a));
  endtask

  initial begin
    logic held;
    logic [2:0] seq2 [9];

    // 1: LDI/LDI/ADD/OUT
    clear_rom();
    rom[0] = 16'h1205; rom[1] = 16'h1407; rom[2] = 16'h2280; rom[3] = 16'hF200;
    rom[4] = 16'hE000;
    #1;
    chk("rst_addr",   32'(address), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid",  32'(result_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    exp_q.push_back(16'd12);
    do_reset();
    for (int i = 1; i <= 4; i++) step_addr(3'(i));
    wait_halt(40);
    chk("t1_haddr", 32'(address), 32'd4);

    // 2: NOP walk with address wrap
    rst = 1'b1;
    clear_rom();
    seq2 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    do_reset();
    for (int i = 0; i < 9; i++) step_addr(seq2[i]);

    // 3: SUB borrow wrap, then ADD back to zero
    rst = 1'b1;
    clear_rom();
    rom[0] = 16'h1201; rom[1] = 16'h3040; rom[2] = 16'hF000;
    rom[3] = 16'h2040; rom[4] = 16'hF000; rom[5] = 16'hE000;
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    do_reset();
    wait_halt(80);
    chk("t3_haddr", 32'(address), 32'd5);

    // 4: BEQZ taken, JMP target truncation, BEQZ not taken
    rst = 1'b1;
    clear_rom();
    rom[0] = 16'h7606; rom[6] = 16'h1601; rom[7] = 16'h800A;
    rom[2] = 16'h7606; rom[3] = 16'hE000;
    do_reset();
    step_addr(3'd6);
    step_addr(3'd7);
    step_addr(3'd2);
    step_addr(3'd3);
    wait_halt(40);

    // 5: HALT at 5 holds outputs, async reset releases it
    rst = 1'b1;
    clear_rom();
    rom[0] = 16'h182A; rom[1] = 16'hF800; rom[2] = 16'h8005; rom[5] = 16'hE000;
    exp_q.push_back(16'h002A);
    do_reset();
    wait_halt(60);
    chk("t5_haddr", 32'(address), 32'd5);
    held = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (address !== 3'd5 || result !== 16'h002A || halted !== 1'b1) held = 1'b0;
    end
    chk("t5_hold", 32'(held), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_addr",   32'(address), 32'd0);
    chk("t5_rst_halted", 32'(halted), 32'd0);
    chk("t5_rst_result", 32'(result), 32'd0);

    // 6: reset mid-EXEC of LDI r1,0x55 must suppress the write
    clear_rom();
    rom[0] = 16'h1403; rom[1] = 16'hF400; rom[2] = 16'h1255; rom[3] = 16'hF200;
    rom[4] = 16'hE000;
    exp_q.push_back(16'h0003);
    do_reset();
    wait_addr(3'd2, 40);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_addr",   32'(address), 32'd0);
    chk("t6_rst_result", 32'(result), 32'd0);
    chk("t6_rst_valid",  32'(result_valid), 32'd0);
    chk("t6_rst_halted", 32'(halted), 32'd0);
    clear_rom();
    rom[0] = 16'hF200; rom[1] = 16'hE000;
    exp_q.push_back(16'h0000);
    @(negedge clk);
    rst = 1'b0;
    wait_halt(40);
    chk("t6_haddr", 32'(address), 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
